// File: rtl/uart_disp_pkg.sv
// Shared ASCII constants, FSM states and character classes for the UART digit buffer.
package uart_disp_pkg;

    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] DEL = 8'h7F;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] ESC = 8'h1B;
    localparam logic [7:0] DOT = 8'h2E;

    typedef enum logic {
        S_NORMAL,
        S_ESC
    } state_t;

    typedef enum logic [2:0] {
        K_DIGIT,
        K_DOT,
        K_BS,
        K_CR,
        K_LF,
        K_ESC,
        K_BAD
    } kind_t;

    typedef enum logic [1:0] {
        C_CLEAR,
        C_BLANK,
        C_BAD
    } esc_cmd_t;

endpackage

// File: rtl/uart_char_decode.sv
// Combinational classifier: maps a received byte to its character kind, digit value
// and the meaning it would have as the byte following ESC.
module uart_char_decode
    import uart_disp_pkg::*;
#(
    parameter bit HEX_EN = 1'b1
) (
    input  logic [7:0] i_byte,
    output kind_t      o_kind,
    output logic [3:0] o_value,
    output esc_cmd_t   o_esc_cmd
);

    always_comb begin
        o_kind    = K_BAD;
        o_value   = 4'h0;
        o_esc_cmd = C_BAD;

        if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
            o_kind  = K_DIGIT;
            o_value = i_byte[3:0];
        end else if (HEX_EN && ((i_byte >= 8'h41 && i_byte <= 8'h46) ||
                                (i_byte >= 8'h61 && i_byte <= 8'h66))) begin
            // 'A'/'a' have low nibble 1, so +9 lands on 10
            o_kind  = K_DIGIT;
            o_value = i_byte[3:0] + 4'd9;
        end else begin
            case (i_byte)
                DOT:     o_kind = K_DOT;
                BS, DEL: o_kind = K_BS;
                CR:      o_kind = K_CR;
                LF:      o_kind = K_LF;
                ESC:     o_kind = K_ESC;
                default: o_kind = K_BAD;
            endcase
        end

        case (i_byte)
            8'h43, 8'h63: o_esc_cmd = C_CLEAR;
            8'h42, 8'h62: o_esc_cmd = C_BLANK;
            default:      o_esc_cmd = C_BAD;
        endcase
    end

endmodule

// File: rtl/uart_digit_buffer.sv
// Line-editing digit buffer: parses the UART byte stream into an edit buffer, commits it
// on CR and drives registered digit, digit-enable and dot-enable vectors to the scanner.
module uart_digit_buffer
    import uart_disp_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter bit HEX_EN        = 1'b1,
    parameter bit LIVE          = 1'b0,
    parameter bit BLANK_LEADING = 1'b1,
    parameter int ESC_TIMEOUT   = 12000000
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rx_data_valid,
    input  logic [7:0]                      rx_data_in,
    output logic [4*NUM_DIGITS-1:0]         seg_data_out,
    output logic [NUM_DIGITS-1:0]           seg_data_en_out,
    output logic [NUM_DIGITS-1:0]           seg_dot_en_out,
    output logic [$clog2(NUM_DIGITS+1)-1:0] digit_cnt_out,
    output logic                            commit_pulse_out,
    output logic                            overflow_out,
    output logic                            bad_char_out
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int TW = (ESC_TIMEOUT > 1) ? $clog2(ESC_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]         MAX_CNT    = CW'(NUM_DIGITS);
    localparam logic [TW-1:0]         TIMER_LOAD = TW'(ESC_TIMEOUT);
    localparam logic [NUM_DIGITS-1:0] EN_RESET   =
        BLANK_LEADING ? NUM_DIGITS'(1) : {NUM_DIGITS{1'b1}};

    state_t                r_state, w_state;
    logic [DW-1:0]         r_edit_data, w_edit_data, r_disp_data, w_disp_data;
    logic [NUM_DIGITS-1:0] r_edit_dot, w_edit_dot, r_disp_dot, w_disp_dot;
    logic [CW-1:0]         r_edit_cnt, w_edit_cnt, r_disp_cnt, w_disp_cnt;
    logic [TW-1:0]         r_esc_timer, w_esc_timer;
    logic                  r_overflow, w_overflow;
    logic                  r_blank_tgl, w_blank_tgl;
    logic                  w_commit, w_bad;

    logic [DW-1:0]         r_seg_data, w_src_data;
    logic [NUM_DIGITS-1:0] r_seg_en, r_seg_dot, w_src_dot, w_en;
    logic [CW-1:0]         r_seg_cnt, w_src_cnt;
    logic                  r_commit, r_bad, w_blank;

    kind_t                 w_kind;
    logic [3:0]            w_value;
    esc_cmd_t              w_esc_cmd;

    uart_char_decode #(.HEX_EN(HEX_EN)) u_decode (
        .i_byte    (rx_data_in),
        .o_kind    (w_kind),
        .o_value   (w_value),
        .o_esc_cmd (w_esc_cmd)
    );

    always_comb begin
        w_state     = r_state;
        w_edit_data = r_edit_data;
        w_edit_dot  = r_edit_dot;
        w_edit_cnt  = r_edit_cnt;
        w_disp_data = r_disp_data;
        w_disp_dot  = r_disp_dot;
        w_disp_cnt  = r_disp_cnt;
        w_esc_timer = r_esc_timer;
        w_overflow  = r_overflow;
        w_blank_tgl = r_blank_tgl;
        w_commit    = 1'b0;
        w_bad       = 1'b0;

        if (r_state == S_ESC) begin
            // A byte wins over the timeout, even in the cycle the timer reads zero
            if (rx_data_valid) begin
                w_state = S_NORMAL;
                case (w_esc_cmd)
                    C_CLEAR: begin
                        w_edit_data = '0;
                        w_edit_dot  = '0;
                        w_edit_cnt  = '0;
                        w_disp_data = '0;
                        w_disp_dot  = '0;
                        w_disp_cnt  = '0;
                        w_overflow  = 1'b0;
                    end
                    C_BLANK: w_blank_tgl = ~r_blank_tgl;
                    default: w_bad = 1'b1;
                endcase
            end else if (r_esc_timer == '0) begin
                w_state = S_NORMAL;
            end else begin
                w_esc_timer = r_esc_timer - TW'(1);
            end
        end else if (rx_data_valid) begin
            case (w_kind)
                K_DIGIT: begin
                    w_edit_data = (r_edit_data << 4) | DW'(w_value);
                    w_edit_dot  = r_edit_dot << 1;
                    if (r_edit_cnt < MAX_CNT) w_edit_cnt = r_edit_cnt + CW'(1);
                    else                      w_overflow = 1'b1;
                end
                K_DOT: begin
                    if (r_edit_cnt != '0) w_edit_dot[0] = 1'b1;
                    else                  w_bad = 1'b1;
                end
                K_BS: begin
                    if (r_edit_cnt != '0) begin
                        w_edit_data = r_edit_data >> 4;
                        w_edit_dot  = r_edit_dot >> 1;
                        w_edit_cnt  = r_edit_cnt - CW'(1);
                    end
                end
                K_CR: begin
                    w_commit   = 1'b1;
                    w_overflow = 1'b0;
                    if (!LIVE) begin
                        w_disp_data = r_edit_data;
                        w_disp_dot  = r_edit_dot;
                        w_disp_cnt  = r_edit_cnt;
                        w_edit_data = '0;
                        w_edit_dot  = '0;
                        w_edit_cnt  = '0;
                    end
                end
                K_LF: ;
                K_ESC: begin
                    w_state     = S_ESC;
                    w_esc_timer = TIMER_LOAD;
                end
                default: w_bad = 1'b1;
            endcase
        end
    end

    // Output vectors are computed from next-state so they appear one cycle after the byte
    always_comb begin
        w_src_data = LIVE ? w_edit_data : w_disp_data;
        w_src_dot  = LIVE ? w_edit_dot  : w_disp_dot;
        w_src_cnt  = LIVE ? w_edit_cnt  : w_disp_cnt;
        w_blank    = BLANK_LEADING ^ w_blank_tgl;
        w_en       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_en[i] = !w_blank || (i == 0) || (CW'(i) < w_src_cnt);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_NORMAL;
            r_edit_data <= '0;
            r_edit_dot  <= '0;
            r_edit_cnt  <= '0;
            r_disp_data <= '0;
            r_disp_dot  <= '0;
            r_disp_cnt  <= '0;
            r_esc_timer <= '0;
            r_overflow  <= 1'b0;
            r_blank_tgl <= 1'b0;
            r_commit    <= 1'b0;
            r_bad       <= 1'b0;
            r_seg_data  <= '0;
            r_seg_en    <= EN_RESET;
            r_seg_dot   <= '0;
            r_seg_cnt   <= '0;
        end else begin
            r_state     <= w_state;
            r_edit_data <= w_edit_data;
            r_edit_dot  <= w_edit_dot;
            r_edit_cnt  <= w_edit_cnt;
            r_disp_data <= w_disp_data;
            r_disp_dot  <= w_disp_dot;
            r_disp_cnt  <= w_disp_cnt;
            r_esc_timer <= w_esc_timer;
            r_overflow  <= w_overflow;
            r_blank_tgl <= w_blank_tgl;
            r_commit    <= w_commit;
            r_bad       <= w_bad;
            r_seg_data  <= w_src_data;
            r_seg_en    <= w_en;
            r_seg_dot   <= w_src_dot & w_en;
            r_seg_cnt   <= w_src_cnt;
        end
    end

    assign seg_data_out     = r_seg_data;
    assign seg_data_en_out  = r_seg_en;
    assign seg_dot_en_out   = r_seg_dot;
    assign digit_cnt_out    = r_seg_cnt;
    assign commit_pulse_out = r_commit;
    assign overflow_out     = r_overflow;
    assign bad_char_out     = r_bad;

endmodule

// File: tb/tb_uart_digit_buffer.sv
// Scoreboard bench for uart_digit_buffer: two instances (HEX_EN=1 and HEX_EN=0) share one
// byte stream; a numeric reference model predicts every cycle's outputs for each.
module tb_uart_digit_buffer;

    localparam int  N       = 6;
    localparam int  TIMEOUT = 16;
    localparam longint MOD  = 64'd16777216;

    typedef struct packed {
        logic [23:0] data;
        logic [5:0]  en;
        logic [5:0]  dot;
        logic [2:0]  cnt;
        logic        commit;
        logic        ovf;
        logic        bad;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxValid = 1'b0;
    logic [7:0]  rxData = 8'h00;

    logic [23:0] segData0, segData1;
    logic [5:0]  segEn0, segEn1, segDot0, segDot1;
    logic [2:0]  cnt0, cnt1;
    logic        commit0, commit1, ovf0, ovf1, bad0, bad1;

    int checks = 0;
    int failures = 0;

    snap_t expQ0[$];
    snap_t expQ1[$];

    longint mEditVal[2], mDispVal[2];
    int     mEditDot[2], mDispDot[2], mEditCnt[2], mDispCnt[2], mTimer[2];
    bit     mOvf[2], mEsc[2], mTgl[2], mCommit[2], mBad[2];

    always #5 clk = ~clk;

    uart_digit_buffer #(.NUM_DIGITS(N), .HEX_EN(1'b1), .LIVE(1'b0),
                        .BLANK_LEADING(1'b1), .ESC_TIMEOUT(TIMEOUT)) dut0 (
        .clk_in(clk), .rst_in(rst), .rx_data_valid(rxValid), .rx_data_in(rxData),
        .seg_data_out(segData0), .seg_data_en_out(segEn0), .seg_dot_en_out(segDot0),
        .digit_cnt_out(cnt0), .commit_pulse_out(commit0), .overflow_out(ovf0),
        .bad_char_out(bad0)
    );

    uart_digit_buffer #(.NUM_DIGITS(N), .HEX_EN(1'b0), .LIVE(1'b0),
                        .BLANK_LEADING(1'b1), .ESC_TIMEOUT(TIMEOUT)) dut1 (
        .clk_in(clk), .rst_in(rst), .rx_data_valid(rxValid), .rx_data_in(rxData),
        .seg_data_out(segData1), .seg_data_en_out(segEn1), .seg_dot_en_out(segDot1),
        .digit_cnt_out(cnt1), .commit_pulse_out(commit1), .overflow_out(ovf1),
        .bad_char_out(bad1)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int digitValue(input logic [7:0] b, input bit hexEn);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (hexEn && b >= "A" && b <= "F") return int'(b) - 55;
        if (hexEn && b >= "a" && b <= "f") return int'(b) - 87;
        return -1;
    endfunction

    task automatic clearModel(input int k);
        mEditVal[k] = 0; mEditDot[k] = 0; mEditCnt[k] = 0;
        mDispVal[k] = 0; mDispDot[k] = 0; mDispCnt[k] = 0;
        mOvf[k] = 0; mEsc[k] = 0; mTgl[k] = 0; mTimer[k] = 0;
    endtask

    // One clock of reference behaviour, described in terms of the digit string rules
    task automatic stepModel(input int k, input bit r, input bit v, input logic [7:0] b, input bit hexEn);
        int d;
        mCommit[k] = 0;
        mBad[k] = 0;
        if (r) begin
            clearModel(k);
        end else if (mEsc[k]) begin
            if (v) begin
                mEsc[k] = 0;
                if (b == "C" || b == "c") begin
                    mEditVal[k] = 0; mEditDot[k] = 0; mEditCnt[k] = 0;
                    mDispVal[k] = 0; mDispDot[k] = 0; mDispCnt[k] = 0;
                    mOvf[k] = 0;
                end else if (b == "B" || b == "b") begin
                    mTgl[k] = !mTgl[k];
                end else begin
                    mBad[k] = 1;
                end
            end else if (mTimer[k] == 0) begin
                mEsc[k] = 0;
            end else begin
                mTimer[k]--;
            end
        end else if (v) begin
            d = digitValue(b, hexEn);
            if (d >= 0) begin
                mEditVal[k] = (mEditVal[k] * 16 + longint'(d)) % MOD;
                mEditDot[k] = (mEditDot[k] * 2) % 64;
                if (mEditCnt[k] == N) mOvf[k] = 1;
                else mEditCnt[k]++;
            end else if (b == 8'h2E) begin
                if (mEditCnt[k] > 0) mEditDot[k] = mEditDot[k] | 1;
                else mBad[k] = 1;
            end else if (b == 8'h08 || b == 8'h7F) begin
                if (mEditCnt[k] > 0) begin
                    mEditVal[k] = mEditVal[k] / 16;
                    mEditDot[k] = mEditDot[k] / 2;
                    mEditCnt[k]--;
                end
            end else if (b == 8'h0D) begin
                mCommit[k] = 1;
                mOvf[k] = 0;
                mDispVal[k] = mEditVal[k]; mDispDot[k] = mEditDot[k]; mDispCnt[k] = mEditCnt[k];
                mEditVal[k] = 0; mEditDot[k] = 0; mEditCnt[k] = 0;
            end else if (b == 8'h1B) begin
                mEsc[k] = 1;
                mTimer[k] = TIMEOUT;
            end else if (b != 8'h0A) begin
                mBad[k] = 1;
            end
        end
    endtask

    function automatic snap_t snapModel(input int k);
        snap_t s;
        int en;
        if (!mTgl[k]) en = ((1 << mDispCnt[k]) - 1) | 1;
        else en = 63;
        s.data   = 24'(mDispVal[k]);
        s.en     = 6'(en);
        s.dot    = 6'(mDispDot[k] & en);
        s.cnt    = 3'(mDispCnt[k]);
        s.commit = mCommit[k];
        s.ovf    = mOvf[k];
        s.bad    = mBad[k];
        return s;
    endfunction

    task automatic applyStimulus(input bit r, input bit v, input logic [7:0] b);
        @(negedge clk);
        rst = r;
        rxValid = v;
        rxData = b;
        stepModel(0, r, v, b, 1'b1);
        stepModel(1, r, v, b, 1'b0);
        expQ0.push_back(snapModel(0));
        expQ1.push_back(snapModel(1));
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b0, 1'b1, b);
    endtask

    task automatic sendString(input string s);
        for (int i = 0; i < s.len(); i++) sendByte(s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic compareSnap(input string who, input snap_t e, input snap_t a);
        checkOutput({who, " seg_data"}, 32'(a.data), 32'(e.data));
        checkOutput({who, " seg_en"},   32'(a.en),   32'(e.en));
        checkOutput({who, " seg_dot"},  32'(a.dot),  32'(e.dot));
        checkOutput({who, " cnt"},      32'(a.cnt),  32'(e.cnt));
        checkOutput({who, " commit"},   32'(a.commit), 32'(e.commit));
        checkOutput({who, " overflow"}, 32'(a.ovf),  32'(e.ovf));
        checkOutput({who, " bad_char"}, 32'(a.bad),  32'(e.bad));
    endtask

    // Monitor: pops one expected snapshot per instance after every active edge
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ0.size() > 0) begin
                e = expQ0.pop_front();
                compareSnap("dut0", e, {segData0, segEn0, segDot0, cnt0, commit0, ovf0, bad0});
            end
            if (expQ1.size() > 0) begin
                e = expQ1.pop_front();
                compareSnap("dut1", e, {segData1, segEn1, segDot1, cnt1, commit1, ovf1, bad1});
            end
        end
    end

    initial begin
        logic [7:0] pool [16];
        int pick;
        clearModel(0);
        clearModel(1);
        pool = '{"0", "5", "9", "a", "F", "c", ".", 8'h08, 8'h7F, 8'h0D, 8'h0A, 8'h1B,
                 "C", "B", "b", "x"};

        repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
        idle(1);
        checkOutput("reset seg_data", 32'(segData0), 32'h0);
        checkOutput("reset seg_en", 32'(segEn0), 32'h01);
        checkOutput("reset cnt", 32'(cnt0), 32'd0);

        sendString("12.3"); sendByte(8'h0D); idle(1);
        checkOutput("12.3 data", 32'(segData0), 32'h000123);
        checkOutput("12.3 dot", 32'(segDot0), 32'b000010);
        checkOutput("12.3 en", 32'(segEn0), 32'b000111);
        checkOutput("12.3 cnt", 32'(cnt0), 32'd3);

        sendString("1234567"); idle(1);
        checkOutput("overflow before CR", 32'(ovf0), 32'd1);
        sendByte(8'h0D); idle(1);
        checkOutput("overflow data", 32'(segData0), 32'h234567);
        checkOutput("overflow after CR", 32'(ovf0), 32'd0);
        checkOutput("overflow en", 32'(segEn0), 32'h3F);

        sendString("98"); sendByte(8'h08); sendString("a"); sendByte(8'h0D); idle(1);
        checkOutput("hex data", 32'(segData0), 32'h00009A);
        checkOutput("hex cnt", 32'(cnt0), 32'd2);
        checkOutput("nohex data", 32'(segData1), 32'h000009);
        checkOutput("nohex cnt", 32'(cnt1), 32'd1);

        sendByte(8'h1B); sendString("C"); idle(1);
        checkOutput("esc clear data", 32'(segData0), 32'h0);
        checkOutput("esc clear en", 32'(segEn0), 32'h01);

        sendString("."); sendByte(8'h08); idle(1);
        checkOutput("empty edit en", 32'(segEn0), 32'b000001);
        checkOutput("empty edit cnt", 32'(cnt0), 32'd0);

        sendString("55"); sendByte(8'h0D); sendByte(8'h1B); sendString("C"); idle(1);
        checkOutput("55 cleared data", 32'(segData0), 32'h0);

        sendByte(8'h1B); idle(20); sendString("7"); sendByte(8'h0D); idle(1);
        checkOutput("after timeout data", 32'(segData0), 32'h7);
        checkOutput("after timeout cnt", 32'(cnt0), 32'd1);

        sendByte(8'h1B); idle(TIMEOUT); sendString("C");
        sendByte(8'h1B); idle(TIMEOUT + 1); sendString("C"); sendByte(8'h0D);
        sendByte(8'h1B); sendString("X"); sendString("3"); sendByte(8'h0D); idle(1);
        checkOutput("esc bad then 3", 32'(segData0), 32'h3);

        sendByte(8'h1B); sendString("B"); idle(1);
        checkOutput("blank off en", 32'(segEn0), 32'h3F);
        sendByte(8'h1B); sendString("b"); idle(1);

        sendString("42"); applyStimulus(1'b1, 1'b1, "5"); sendByte(8'h0D); idle(1);
        checkOutput("reset drops byte", 32'(segData0), 32'h0);
        checkOutput("reset drops cnt", 32'(cnt0), 32'd0);

        for (int i = 0; i < 600; i++) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 1) applyStimulus(1'b1, 1'b0, 8'h00);
            else if (pick < 30) idle(1);
            else if (pick < 35) sendByte(8'($urandom));
            else sendByte(pool[$urandom_range(0, 15)]);
        end

        idle(2);
        @(negedge clk);
        checkOutput("scoreboard drained", 32'(expQ0.size() + expQ1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_digit_buffer.md
Name: uart_digit_buffer

Overview:
- Parametrised line-editing buffer between the UART byte receiver and the segment scan driver.
- Parses the received ASCII stream (hex digits, dot, backspace, CR, ESC commands) into an N-digit edit buffer.
- Commits the edit buffer to a display register on CR and drives packed digit, digit-enable and dot-enable vectors to the scanner.
- Adds leading-blank suppression, overflow and bad-character flags, and an ESC command FSM with timeout.

Parameters:
- NUM_DIGITS, 6, number of display digits, legal range 1..8.
- HEX_EN, 1, 1 accepts 'A'-'F'/'a'-'f' as values 10-15; 0 treats them as bad characters.
- LIVE, 0, 0 shows only committed data; 1 shows the edit buffer directly.
- BLANK_LEADING, 1, 1 disables digits above the entered count.
- ESC_TIMEOUT, 12000000, cycles S_ESC waits for its command byte.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, synchronous, active-high.
- rx_data_valid  in  1  one-cycle strobe, rx_data_in valid.
- rx_data_in  in  8  received byte.
- seg_data_out  out  4*NUM_DIGITS  digit i at [4i+:4]; i=0 is the rightmost digit.
- seg_data_en_out  out  NUM_DIGITS  per-digit display enable.
- seg_dot_en_out  out  NUM_DIGITS  per-digit dot enable.
- digit_cnt_out  out  $clog2(NUM_DIGITS+1)  digits in the displayed buffer.
- commit_pulse_out  out  1  one-cycle pulse per CR.
- overflow_out  out  1  sticky, a digit was pushed off the left edge.
- bad_char_out  out  1  one-cycle pulse, byte rejected.

Behaviour:
- Registers: edit_data, edit_dot, edit_cnt; disp_data, disp_dot, disp_cnt; state; esc_timer.
- All outputs registered. Byte accepted in cycle N, so outputs and pulses update at N+1.
- Back-to-back valid cycles are each processed.
- Reset: rst_in has priority over rx_data_valid. All registers cleared, state=S_NORMAL. All outputs 0 except seg_data_en_out: bit0 only when BLANK_LEADING=1, all ones when 0.
- S_NORMAL, digit byte: edit_data <= {edit_data<<4 | value}; edit_dot <= edit_dot<<1 with bit0=0.
  - If edit_cnt<NUM_DIGITS: edit_cnt+1.
  - Else edit_cnt unchanged, the MS digit is discarded and overflow_out is set.
- '.': sets edit_dot[0] if edit_cnt>0. An already-set dot is a no-op. If edit_cnt==0, bad_char pulse and no change.
- 0x08 or 0x7F: if edit_cnt>0, shift data right 4 and dot right 1, fill top with 0, edit_cnt-1. If edit_cnt==0, no change and no flag.
- 0x0D (CR): commit_pulse_out at N+1.
  - LIVE=0: disp_* <= edit_*; edit buffer cleared; overflow cleared.
  - LIVE=1: edit buffer retained; overflow cleared.
- 0x0A: ignored silently.
- 0x1B: state -> S_ESC, esc_timer loaded with ESC_TIMEOUT.
- Any other byte: bad_char pulse, no state change.
- S_ESC: esc_timer decrements every cycle.
  - Next valid byte 'C'/'c': clear edit, disp and overflow.
  - Next valid byte 'B'/'b': toggle blank mode; the toggle XORs BLANK_LEADING.
  - Any other byte: bad_char pulse.
  - Every case returns to S_NORMAL.
  - Timer reaching 0 with no byte: return to S_NORMAL silently.
  - A byte arriving in the same cycle the timer hits 0 is processed as the ESC command.
- Output source: edit_* when LIVE=1, else disp_*.
- Digit enable (cnt = source count):
  - Blank mode on: enable bit i = (i<cnt) | (i==0), so the rightmost digit always shows, "0" when empty.
  - Blank mode off: all enabled.
  - seg_dot_en_out = source dot & seg_data_en_out.
- digit_cnt_out = source count.

Decomposition:
- Package uart_disp_pkg:
  - ASCII constants: BS, DEL, CR, LF, ESC, DOT.
  - state enum {S_NORMAL, S_ESC}.
  - char-kind enum {K_DIGIT, K_DOT, K_BS, K_CR, K_LF, K_ESC, K_BAD}.
- Sub-module uart_char_decode: combinational byte classifier.
  - Inputs: byte, HEX_EN.
  - Outputs: kind, 4-bit value, plus the ESC-command decode.
- Buffers, FSM and timer stay in the top.

Test Plan (NUM_DIGITS=6, LIVE=0, BLANK_LEADING=1, ESC_TIMEOUT=16):
- "1","2",".","3",CR -> commit pulse once; seg_data_out=24'h000123, seg_dot_en_out=6'b000010, seg_data_en_out=6'b000111, digit_cnt_out=3.
- "1234567",CR -> seg_data_out=24'h234567, overflow_out=1 before CR and 0 after; all six digits enabled.
- "9","8",0x08,"a",CR with HEX_EN=1 -> 24'h00009A, cnt=2; repeat with HEX_EN=0 -> bad_char pulse on "a", result 24'h000009, cnt=1.
- ".", 0x08 on empty buffer -> bad_char pulse on "." only; nothing changes; seg_data_en_out=6'b000001.
- "55",CR then ESC,"C" -> all outputs back to reset values. ESC then 20 idle cycles then "7" -> "7" processed as a digit (edit cnt 1). ESC,"X" -> bad_char pulse, state returns to S_NORMAL.
- Assert rst_in in the same cycle as rx_data_valid with "5" mid-edit -> byte dropped; all registers clear at the next edge.
